// File: rtl/wishbone_slave_ram.sv
// Classic Wishbone 8-bit slave with an internal byte RAM.
// Decodes a 16-bit window and acks after a fixed number of wait states.
module wishbone_slave_ram #(
    parameter int          AW          = 8,
    parameter logic [15:0] BASE_ADDR   = 16'h0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [15:0] adr_i,
    input  logic [7:0]  dat_i,
    output logic [7:0]  dat_o,
    input  logic        we_i,
    input  logic        stb_i,
    input  logic        cyc_i,
    output logic        ack_o
);

    localparam logic [3:0] LP_WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [3:0]     r_cnt;
    logic [AW-1:0]  r_adr;
    logic [7:0]     r_dat;
    logic           r_we;
    logic [7:0]     r_rdata;
    logic [7:0]     r_mem [2**AW];

    logic           w_req;
    logic           w_hit;
    logic           w_ack;
    logic [AW-1:0]  w_rd_adr;

    assign w_req = cyc_i & stb_i;
    assign w_hit = w_req & (adr_i[15:AW] == BASE_ADDR[15:AW]);
    assign w_ack = (r_state == ST_ACK) & w_req;

    // With zero wait states the address is not latched yet when ACK is entered
    assign w_rd_adr = (r_state == ST_IDLE) ? adr_i[AW-1:0] : r_adr;

    assign ack_o = w_ack;
    assign dat_o = w_ack ? r_rdata : 8'h00;

    // Next-state decode
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_hit) begin
                    w_next = (LP_WS != 4'd0) ? ST_WAIT : ST_ACK;
                end
            end
            ST_WAIT: begin
                if (!w_req) begin
                    w_next = ST_IDLE;
                end else if (r_cnt == 4'd1) begin
                    w_next = ST_ACK;
                end
            end
            ST_ACK: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // State, request latches, wait counter and read buffer
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_adr   <= '0;
            r_dat   <= 8'h00;
            r_we    <= 1'b0;
            r_rdata <= 8'h00;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && w_hit) begin
                r_adr <= adr_i[AW-1:0];
                r_dat <= dat_i;
                r_we  <= we_i;
                r_cnt <= LP_WS;
            end else if (r_state == ST_WAIT && w_req) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_next == ST_ACK && r_state != ST_ACK) begin
                r_rdata <= r_mem[w_rd_adr];
            end
        end
    end

    // RAM write commits only if the ack was actually seen by the master
    always_ff @(posedge clk_i) begin
        if (w_ack && r_we) begin
            r_mem[r_adr] <= r_dat;
        end
    end

endmodule

// File: tb/tb_wishbone_slave_ram.sv
// Directed bench for wishbone_slave_ram.
// Four instances cover the wait-state and window configurations.
module tb_wishbone_slave_ram;

    logic        clk;
    logic        rst_n;
    logic [15:0] adr;
    logic [7:0]  dat;
    logic        we;
    logic        stb;
    logic        cyc;
    int          sel;

    logic [3:0]  cyc_v;
    logic [3:0]  ack_v;
    logic [7:0]  dat_v [4];

    int n_checks;
    int n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign cyc_v[0] = cyc && (sel == 0);
    assign cyc_v[1] = cyc && (sel == 1);
    assign cyc_v[2] = cyc && (sel == 2);
    assign cyc_v[3] = cyc && (sel == 3);

    wishbone_slave_ram #(.AW(8), .BASE_ADDR(16'h0000), .WAIT_STATES(1)) u_dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .adr_i(adr), .dat_i(dat),
        .dat_o(dat_v[0]), .we_i(we), .stb_i(stb), .cyc_i(cyc_v[0]),
        .ack_o(ack_v[0])
    );

    wishbone_slave_ram #(.AW(8), .BASE_ADDR(16'h0000), .WAIT_STATES(0)) u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .adr_i(adr), .dat_i(dat),
        .dat_o(dat_v[1]), .we_i(we), .stb_i(stb), .cyc_i(cyc_v[1]),
        .ack_o(ack_v[1])
    );

    wishbone_slave_ram #(.AW(8), .BASE_ADDR(16'h1000), .WAIT_STATES(1)) u_dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .adr_i(adr), .dat_i(dat),
        .dat_o(dat_v[2]), .we_i(we), .stb_i(stb), .cyc_i(cyc_v[2]),
        .ack_o(ack_v[2])
    );

    wishbone_slave_ram #(.AW(8), .BASE_ADDR(16'h0000), .WAIT_STATES(3)) u_dut3 (
        .clk_i(clk), .rst_n_i(rst_n), .adr_i(adr), .dat_i(dat),
        .dat_o(dat_v[3]), .we_i(we), .stb_i(stb), .cyc_i(cyc_v[3]),
        .ack_o(ack_v[3])
    );

    typedef struct {
        int          s;
        logic        w;
        logic [15:0] a;
        logic [7:0]  d;
        int          ek;
        logic [7:0]  ed;
    } vec_t;

    localparam int NV = 16;
    vec_t vt [NV];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One transfer; ek is the ack cycle counted from the drive edge, 0 = none
    task automatic xfer(input int s, input logic w, input logic [15:0] a,
                        input logic [7:0] d, input int ek,
                        input logic [7:0] ed, input string nm);
        int         gk;
        logic [7:0] gd;
        bit         idle_bad;
        gk       = 0;
        gd       = 8'h00;
        idle_bad = 1'b0;
        @(posedge clk);
        #1;
        sel = s; we = w; adr = a; dat = d; cyc = 1'b1; stb = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (ack_v[s]) begin
                gk = k;
                gd = dat_v[s];
                break;
            end else if (dat_v[s] != 8'h00) begin
                idle_bad = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0;
        chk({nm, "_ack_cycle"}, gk, ek);
        chk({nm, "_dat_idle_zero"}, int'(idle_bad), 0);
        if (!w && ek != 0) begin
            chk({nm, "_rdata"}, int'(gd), int'(ed));
        end
    endtask

    initial begin
        int         gk;
        logic [3:0] pat;
        logic [7:0] d1;
        logic [7:0] d2;
        bit         seen;

        n_checks = 0;
        n_err    = 0;
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        adr = 16'h0000; dat = 8'h00; sel = 0;

        vt[0]  = '{0, 1'b1, 16'h0012, 8'hA5, 2, 8'h00};
        vt[1]  = '{0, 1'b0, 16'h0012, 8'h00, 2, 8'hA5};
        vt[2]  = '{0, 1'b1, 16'h00FF, 8'h01, 2, 8'h00};
        vt[3]  = '{0, 1'b0, 16'h00FF, 8'h00, 2, 8'h01};
        vt[4]  = '{1, 1'b1, 16'h0001, 8'h11, 1, 8'h00};
        vt[5]  = '{1, 1'b1, 16'h0002, 8'h22, 1, 8'h00};
        vt[6]  = '{1, 1'b0, 16'h0001, 8'h00, 1, 8'h11};
        vt[7]  = '{1, 1'b0, 16'h0002, 8'h00, 1, 8'h22};
        vt[8]  = '{2, 1'b1, 16'h2003, 8'h5A, 0, 8'h00};
        vt[9]  = '{2, 1'b1, 16'h1003, 8'h5A, 2, 8'h00};
        vt[10] = '{2, 1'b0, 16'h1003, 8'h00, 2, 8'h5A};
        vt[11] = '{3, 1'b1, 16'h0005, 8'hC3, 4, 8'h00};
        vt[12] = '{3, 1'b0, 16'h0005, 8'h00, 4, 8'hC3};
        vt[13] = '{3, 1'b1, 16'h0020, 8'h10, 4, 8'h00};
        vt[14] = '{3, 1'b1, 16'h0021, 8'h99, 4, 8'h00};
        vt[15] = '{3, 1'b0, 16'h0021, 8'h00, 4, 8'h99};

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset_ack%0d", i), int'(ack_v[i]), 0);
            chk($sformatf("reset_dat%0d", i), int'(dat_v[i]), 0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            xfer(vt[i].s, vt[i].w, vt[i].a, vt[i].d, vt[i].ek, vt[i].ed,
                 $sformatf("vec%0d", i));
        end

        // Back-to-back reads with strobe held, zero wait states
        @(posedge clk);
        #1;
        sel = 1; we = 1'b0; adr = 16'h0001; cyc = 1'b1; stb = 1'b1;
        pat = 4'b0000; d1 = 8'h00; d2 = 8'h00;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            pat[k-1] = ack_v[1];
            if (k == 1) begin
                d1  = dat_v[1];
                adr = 16'h0002;
            end
            if (k == 3) d2 = dat_v[1];
        end
        cyc = 1'b0; stb = 1'b0;
        chk("b2b_ack_pattern", int'(pat), 4'b0101);
        chk("b2b_data1", int'(d1), 8'h11);
        chk("b2b_data2", int'(d2), 8'h22);

        // Abort during wait states discards the write
        @(posedge clk);
        #1;
        sel = 3; we = 1'b1; adr = 16'h0005; dat = 8'h3C;
        cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        #1;
        cyc  = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ack_v[3]) seen = 1'b1;
        end
        stb = 1'b0;
        chk("abort_no_ack", int'(seen), 0);
        xfer(3, 1'b0, 16'h0005, 8'h00, 4, 8'hC3, "abort_readback");

        // Reset in the middle of an ACK cycle
        @(posedge clk);
        #1;
        sel = 0; we = 1'b1; adr = 16'h0012; dat = 8'hFF;
        cyc = 1'b1; stb = 1'b1;
        gk = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (ack_v[0]) begin
                gk = k;
                break;
            end
        end
        chk("rst_pre_ack", gk, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_ack_drop", int'(ack_v[0]), 0);
        chk("rst_dat_drop", int'(dat_v[0]), 0);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        xfer(0, 1'b0, 16'h0012, 8'h00, 2, 8'hA5, "rst_readback");

        // Address/data changes during wait states are ignored
        @(posedge clk);
        #1;
        sel = 3; we = 1'b1; adr = 16'h0020; dat = 8'h77;
        cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        #1;
        adr = 16'h0021; dat = 8'hEE;
        gk = 0;
        for (int k = 2; k <= 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (ack_v[3]) begin
                gk = k;
                break;
            end
        end
        @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0;
        chk("latch_ack_cycle", gk, 4);
        xfer(3, 1'b0, 16'h0020, 8'h00, 4, 8'h77, "latch_rd20");
        xfer(3, 1'b0, 16'h0021, 8'h00, 4, 8'h99, "latch_rd21");
        xfer(3, 1'b0, 16'h0005, 8'h00, 4, 8'hC3, "latch_rd05");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
